// File: rtl/acu_reservation_station_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types
//   Types shared by the ACU reservation station and its ALU.
//   acu_op_t   : ALU operation. Encodings 10..15 are undefined.
//   sal_t      : {tag, rdy, data}. Used for operands, broadcast results and
//                station results. data is meaningful only when rdy=1.
//   rs_entry_t : one reservation-station slot.
// -----------------------------------------------------------------------------
package rv32i_types;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  typedef enum logic [3:0] {
    ACU_ADD  = 4'd0,
    ACU_SUB  = 4'd1,
    ACU_SLL  = 4'd2,
    ACU_SLT  = 4'd3,
    ACU_SLTU = 4'd4,
    ACU_XOR  = 4'd5,
    ACU_SRL  = 4'd6,
    ACU_SRA  = 4'd7,
    ACU_OR   = 4'd8,
    ACU_AND  = 4'd9
  } acu_op_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             rdy;
    logic [XLEN-1:0]  data;
  } sal_t;

  typedef struct packed {
    logic             busy;
    acu_op_t          op;
    logic [TAG_W-1:0] rob_tag;
    sal_t             src1;
    sal_t             src2;
  } rs_entry_t;

  // An entry may issue once it holds an instruction and both operands.
  function automatic logic entry_ready(rs_entry_t e);
    return e.busy & e.src1.rdy & e.src2.rdy;
  endfunction

endpackage

// File: rtl/acu_reservation_station_alu.sv
// -----------------------------------------------------------------------------
// acu_alu
//   Purely combinational ALU shared by all station entries.
//   op_i     : operation
//   a_i, b_i : operands; shifts use b_i[4:0] as the amount
//   result_o : result modulo 2^width; undefined ops give 0
// -----------------------------------------------------------------------------
module acu_alu
  import rv32i_types::*;
#(
  parameter int width = 32
) (
  input  acu_op_t          op_i,
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] result_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ACU_ADD:  result_o = a_i + b_i;
      ACU_SUB:  result_o = a_i - b_i;
      ACU_SLL:  result_o = a_i << shamt;
      ACU_SRL:  result_o = a_i >> shamt;
      ACU_SRA:  result_o = width'($signed(a_i) >>> shamt);
      ACU_SLT:  result_o = {{(width-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ACU_SLTU: result_o = {{(width-1){1'b0}}, (a_i < b_i)};
      ACU_XOR:  result_o = a_i ^ b_i;
      ACU_OR:   result_o = a_i | b_i;
      ACU_AND:  result_o = a_i & b_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/acu_reservation_station.sv
// -----------------------------------------------------------------------------
// acu_reservation_station
//   Holds ROB-dispatched ALU instructions until both operands are ready,
//   snoops the ROB broadcast bus for missing operands, issues one ready entry
//   per cycle (lowest index first) to a shared ALU and returns the result in
//   the issuing slot of acu_rs_o for exactly one cycle.
//
//   clk, rst          : clock, asynchronous active-high reset
//   load              : dispatch strobe from the ROB
//   rd_tag, op        : ROB tag and operation of the dispatched instruction
//   src1, src2        : operands {tag, rdy, data}
//   rob_broadcast_bus : completed ROB results, indexed by ROB tag
//   acu_rs_o          : per-slot result, valid for one cycle when rdy=1
//   stall             : all entries busy; dispatch must be held off
//
//   sal_t data is XLEN bits, so width must stay equal to XLEN.
// -----------------------------------------------------------------------------
module acu_reservation_station
  import rv32i_types::*;
#(
  parameter int width    = 32,
  parameter int size     = 8,
  parameter int rob_size = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TAG_W-1:0] rd_tag,
  input  acu_op_t          op,
  input  sal_t             src1,
  input  sal_t             src2,
  input  sal_t             rob_broadcast_bus [rob_size],
  output sal_t             acu_rs_o          [size],
  output logic             stall
);

  localparam int IDX_W = (size > 1) ? $clog2(size) : 1;
  localparam int BUS_W = (rob_size > 1) ? $clog2(rob_size) : 1;

  rs_entry_t entries_q [size];
  rs_entry_t entries_d [size];
  sal_t      out_q     [size];
  sal_t      out_d     [size];

  logic [size-1:0]  busy_vec;
  logic [size-1:0]  ready_vec;
  logic             issue_valid;
  logic [IDX_W-1:0] issue_idx;
  logic [IDX_W-1:0] free_idx;

  acu_op_t          issue_op;
  logic [width-1:0] issue_a;
  logic [width-1:0] issue_b;
  logic [TAG_W-1:0] issue_tag;
  logic [width-1:0] alu_result;

  // Broadcast tags are implied by the bus index and never read.
  logic unused_bus_tags;

  // Returns the operand with bus data captured if it is still waiting and
  // its producer is broadcasting this cycle. Out-of-range tags never match.
  function automatic sal_t snoop(sal_t s);
    sal_t r;
    r = s;
    if (!s.rdy && (int'(s.tag) < rob_size) &&
        rob_broadcast_bus[s.tag[BUS_W-1:0]].rdy) begin
      r.rdy  = 1'b1;
      r.data = rob_broadcast_bus[s.tag[BUS_W-1:0]].data;
    end
    return r;
  endfunction

  always_comb begin
    unused_bus_tags = 1'b0;
    for (int i = 0; i < rob_size; i++) begin
      unused_bus_tags = unused_bus_tags ^ (^rob_broadcast_bus[i].tag);
    end
  end

  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < size; i++) begin
      busy_vec[i]  = entries_q[i].busy;
      ready_vec[i] = entry_ready(entries_q[i]);
    end
  end

  // An issuing entry is still busy this cycle, so stall ignores issue.
  assign stall = &busy_vec;

  // Lowest-index priority: scan downwards so the last hit is the lowest.
  always_comb begin
    issue_valid = 1'b0;
    issue_idx   = '0;
    free_idx    = '0;
    for (int i = size - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        issue_valid = 1'b1;
        issue_idx   = IDX_W'(i);
      end
      if (!busy_vec[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    issue_op  = entries_q[issue_idx].op;
    issue_a   = entries_q[issue_idx].src1.data;
    issue_b   = entries_q[issue_idx].src2.data;
    issue_tag = entries_q[issue_idx].rob_tag;
  end

  acu_alu #(
    .width (width)
  ) u_alu (
    .op_i     (issue_op),
    .a_i      (issue_a),
    .b_i      (issue_b),
    .result_o (alu_result)
  );

  always_comb begin
    // NOTE: every output of this block is given a full default first, so no
    // path leaves a value unassigned and no latch is inferred.
    entries_d = entries_q;
    for (int i = 0; i < size; i++) begin
      out_d[i] = '0;
    end

    // Wakeup: issue reads registered rdy, so a woken operand issues next edge.
    for (int i = 0; i < size; i++) begin
      if (entries_q[i].busy) begin
        entries_d[i].src1 = snoop(entries_q[i].src1);
        entries_d[i].src2 = snoop(entries_q[i].src2);
      end
    end

    if (issue_valid) begin
      entries_d[issue_idx] = '0;
      out_d[issue_idx]     = '{tag: issue_tag, rdy: 1'b1, data: alu_result};
    end

    // The free slot is never the issuing slot (that one is still busy), so a
    // slot freed by issue becomes available only from the next cycle.
    if (load && !stall) begin
      entries_d[free_idx] = '{busy:    1'b1,
                              op:      op,
                              rob_tag: rd_tag,
                              src1:    snoop(src1),
                              src2:    snoop(src2)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the entry and result arrays are control state (busy/rdy), so
      // every element is reset rather than left for software to initialise.
      for (int i = 0; i < size; i++) begin
        entries_q[i] <= '0;
        out_q[i]     <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so all state updates from the same
      // pre-edge values regardless of statement order.
      entries_q <= entries_d;
      out_q     <= out_d;
    end
  end

  assign acu_rs_o = out_q;

  // Dispatch into a full station is a ROB protocol error; it is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_no_load_when_full: assert (!(load && stall));
    end
  end

endmodule

// File: tb/tb_acu_reservation_station.sv
// -----------------------------------------------------------------------------
// tb_acu_reservation_station
//   Directed bench for acu_reservation_station. Inputs change and outputs are
//   sampled on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_acu_reservation_station;
  import rv32i_types::*;

  logic    clk;
  logic    rst;
  logic    load;
  logic [3:0] rd_tag;
  acu_op_t op;
  sal_t    src1;
  sal_t    src2;
  sal_t    bus    [8];
  sal_t    rs_out [8];
  logic    stall;

  int n_checks = 0;
  int n_fail   = 0;

  acu_reservation_station #(
    .width    (32),
    .size     (8),
    .rob_size (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .load              (load),
    .rd_tag            (rd_tag),
    .op                (op),
    .src1              (src1),
    .src2              (src2),
    .rob_broadcast_bus (bus),
    .acu_rs_o          (rs_out),
    .stall             (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic sal_t mk(input logic [3:0] t, input logic r, input logic [31:0] d);
    sal_t s;
    s.tag  = t;
    s.rdy  = r;
    s.data = d;
    return s;
  endfunction

  task automatic idle();
    load   = 1'b0;
    rd_tag = '0;
    op     = ACU_ADD;
    src1   = '0;
    src2   = '0;
    for (int i = 0; i < 8; i++) bus[i] = '0;
  endtask

  task automatic drive(input logic [3:0] t, input acu_op_t o, input sal_t s1, input sal_t s2);
    load   = 1'b1;
    rd_tag = t;
    op     = o;
    src1   = s1;
    src2   = s2;
  endtask

  // Dispatch a fully ready instruction into an empty station and check the
  // result in slot 0 one edge later.
  task automatic alu_case(input string name, input acu_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    drive(4'd1, o, mk(4'd0, 1'b1, a), mk(4'd0, 1'b1, b));
    @(negedge clk);
    idle();
    @(negedge clk);
    check(name, rs_out[0], mk(4'd1, 1'b1, exp));
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    acu_op_t bad_op;

    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    check("reset_stall", stall, 1'b0);
    check("reset_out0", rs_out[0], '0);
    check("reset_out7", rs_out[7], '0);
    rst = 1'b0;

    // Ready dispatch: 5 + 7 -> slot 0 one edge later, gone the edge after.
    drive(4'd3, ACU_ADD, mk(4'd0, 1'b1, 32'd5), mk(4'd0, 1'b1, 32'd7));
    @(negedge clk);
    idle();
    check("rdy_early", rs_out[0], '0);
    @(negedge clk);
    check("rdy_result", rs_out[0], mk(4'd3, 1'b1, 32'd12));
    @(negedge clk);
    check("rdy_clear", rs_out[0], '0);

    // Wakeup: src1 waits on tag 5, broadcast two cycles after dispatch.
    drive(4'd2, ACU_SUB, mk(4'd5, 1'b0, 32'd0), mk(4'd0, 1'b1, 32'd4));
    @(negedge clk);
    idle();
    @(negedge clk);
    check("wk_waiting", rs_out[0], '0);
    bus[5] = mk(4'd5, 1'b1, 32'd10);
    @(negedge clk);
    idle();
    check("wk_capture_no_issue", rs_out[0], '0);
    @(negedge clk);
    check("wk_result", rs_out[0], mk(4'd2, 1'b1, 32'd6));
    @(negedge clk);
    check("wk_clear", rs_out[0], '0);

    // Dispatch bypass: the awaited result is on the bus in the load cycle.
    drive(4'd4, ACU_SRA, mk(4'd6, 1'b0, 32'd0), mk(4'd0, 1'b1, 32'd4));
    bus[6] = mk(4'd6, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("byp_result", rs_out[0], mk(4'd4, 1'b1, 32'hFFFF_FFFF));
    @(negedge clk);
    check("byp_clear", rs_out[0], '0);

    // Full station: eight entries all waiting on tag 7.
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_nostall_%0d", i), stall, 1'b0);
      drive(4'(i), ACU_ADD, mk(4'd7, 1'b0, 32'd0), mk(4'd0, 1'b1, 32'(i)));
      @(negedge clk);
    end
    idle();
    check("full_stall", stall, 1'b1);
    bus[7] = mk(4'd7, 1'b1, 32'd1);
    @(negedge clk);
    idle();
    check("full_stall_after_wake", stall, 1'b1);
    check("full_no_issue_yet", rs_out[0], '0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("full_issue_%0d", k), rs_out[k], mk(4'(k), 1'b1, 32'(k + 1)));
      check($sformatf("full_stall_drop_%0d", k), stall, 1'b0);
      if (k > 0) check($sformatf("full_prev_clear_%0d", k), rs_out[k-1], '0);
    end
    @(negedge clk);
    check("full_last_clear", rs_out[7], '0);

    // ALU sweep.
    bad_op = acu_op_t'(4'd15);
    alu_case("alu_slt_neg",  ACU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1);
    alu_case("alu_slt_pos",  ACU_SLT,  32'd1,         32'hFFFF_FFFF, 32'd0);
    alu_case("alu_sltu",     ACU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0);
    alu_case("alu_sll33",    ACU_SLL,  32'd1,         32'd33,        32'd2);
    alu_case("alu_srl",      ACU_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000);
    alu_case("alu_sra",      ACU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000);
    alu_case("alu_sub_wrap", ACU_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE);
    alu_case("alu_add_wrap", ACU_ADD,  32'hFFFF_FFFF, 32'd2,         32'd1);
    alu_case("alu_xor",      ACU_XOR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    alu_case("alu_or",       ACU_OR,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    alu_case("alu_and",      ACU_AND,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    alu_case("alu_undef",    bad_op,   32'h1234_5678, 32'h1111_1111, 32'd0);

    // Same-cycle dispatch into slot 1 while slot 0 issues.
    drive(4'd5, ACU_ADD, mk(4'd0, 1'b1, 32'd1), mk(4'd0, 1'b1, 32'd2));
    @(negedge clk);
    drive(4'd6, ACU_ADD, mk(4'd0, 1'b1, 32'd10), mk(4'd0, 1'b1, 32'd20));
    @(negedge clk);
    idle();
    check("dual_issue_a", rs_out[0], mk(4'd5, 1'b1, 32'd3));
    check("dual_slot1_idle", rs_out[1], '0);
    @(negedge clk);
    check("dual_issue_b", rs_out[1], mk(4'd6, 1'b1, 32'd30));
    check("dual_slot0_clear", rs_out[0], '0);
    @(negedge clk);

    // Reset mid-run: slots 0,2,3 wait on tag 3, slot 1 woken via tag 4.
    drive(4'd0, ACU_ADD, mk(4'd3, 1'b0, 32'd0), mk(4'd0, 1'b1, 32'd0));
    @(negedge clk);
    drive(4'd1, ACU_ADD, mk(4'd4, 1'b0, 32'd0), mk(4'd0, 1'b1, 32'd1));
    @(negedge clk);
    drive(4'd2, ACU_ADD, mk(4'd3, 1'b0, 32'd0), mk(4'd0, 1'b1, 32'd2));
    @(negedge clk);
    drive(4'd3, ACU_ADD, mk(4'd3, 1'b0, 32'd0), mk(4'd0, 1'b1, 32'd3));
    bus[4] = mk(4'd4, 1'b1, 32'd7);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("mid_pre_out1", rs_out[1], mk(4'd1, 1'b1, 32'd8));
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_stall", stall, 1'b0);
    for (int i = 0; i < 8; i++) check($sformatf("mid_rst_out%0d", i), rs_out[i], '0);
    @(negedge clk);
    rst = 1'b0;
    bus[3] = mk(4'd3, 1'b1, 32'd9);
    @(negedge clk);
    idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) check($sformatf("mid_no_issue_c%0d_s%0d", c, i), rs_out[i], '0);
    end
    check("mid_end_stall", stall, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acu_reservation_station.md
Name: acu_reservation_station

Overview:
Arithmetic/compute-unit reservation station on the dispatch side of the reorder buffer. It accepts instructions dispatched by the ROB, which are tagged with the ROB slot, and holds them until their source operands are ready. It snoops the ROB broadcast bus for missing operands, executes ready entries on one shared ALU, and returns results to the ROB as a per-slot sal_t array. It drives stall_acu back to the ROB.

Parameters:
width, 32, datapath width
size, 8, number of station entries and length of the result array
rob_size, 8, ROB depth and length of the broadcast bus; tags are 4 bits

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
load  input  1  dispatch strobe (load_acu_rs from ROB)
rd_tag  input  4  ROB tag of the dispatched instruction
op  input  acu_op_t  ALU operation of the dispatched instruction
src1  input  sal_t  operand 1: tag, rdy, data (data valid when rdy=1)
src2  input  sal_t  operand 2: same format; immediate/PC arrive with rdy=1
rob_broadcast_bus  input  sal_t[rob_size]  completed results, indexed by ROB tag
acu_rs_o  output  sal_t[size]  result per station slot; rdy=1 means valid
stall  output  1  no free entry; drives stall_acu

Behaviour:
- Entry state: busy, op, rob tag, and per operand {rdy, tag, data}. All are cleared on rst.
- Reset (async, active-high): all entries go not-busy. Every acu_rs_o[i] goes to all-zero. stall=0.
- stall is combinational: it is 1 iff all entries are busy. An entry issuing this cycle still counts as busy, so stall does not depend on issue.
- Dispatch: when load=1 and stall=0, the lowest-index non-busy entry is written at the clock edge. load while stall=1 is a protocol error; the station ignores it and an assertion flags it.
- Dispatch bypass: if srcN.rdy=0 and rob_broadcast_bus[srcN.tag].rdy=1 in the load cycle, the entry captures the bus data with rdy=1. This prevents losing a result broadcast in the same cycle.
- Wakeup: each cycle, every busy entry with operand N not ready checks rob_broadcast_bus[tagN]. If .rdy=1, it captures .data and sets rdy=1 at the edge. Multiple entries may wake in the same cycle.
- Issue: select the lowest-index entry with busy=1 and both operands ready, as of the current registered state. Only one entry issues per cycle.
- Completion: the ALU computes the result combinationally. At the edge, acu_rs_o[k] is loaded with {tag = entry rob tag, rdy = 1, data = result}, where k is the issuing slot, and entry k is cleared to not-busy.
- acu_rs_o[k] stays valid for exactly one cycle. The next edge clears it to zero unless slot k issues again.
- Latency: an entry dispatched with both operands ready at edge N has its result visible on acu_rs_o from edge N+1 to edge N+2.
- Operand woken by broadcast at edge N: the earliest issue edge is N+1.
- A freed slot is reusable for dispatch in the cycle after it issues. It is not reusable in the same cycle.
- Simultaneous events: dispatch into slot j and issue from slot k (j≠k) in the same cycle are both performed. Wakeup and issue of the same entry in the same cycle do not occur, because issue reads registered rdy.
- ALU arithmetic, all modulo 2^width:
  - add, sub
  - sll, srl, sra: shift amount is src2[4:0]
  - slt (signed), sltu (unsigned): result is 32'd0 or 32'd1
  - xor, or, and
  - Undefined op values produce 0.
- Wrap-around: tags 0..rob_size-1 only. There is no age ordering, so the lowest index wins.

Decomposition:
- Shared rv32i_types package:
  - acu_op_t enum (add, sub, sll, slt, sltu, xor, srl, sra, or, and)
  - the existing sal_t
  - new rs_entry_t struct
- One sub-module: acu_alu, a purely combinational op/a/b -> result unit. It is instantiated once.

Test Plan:
- Reset mid-run: with 3 entries busy and acu_rs_o[1].rdy=1, pulse rst asynchronously -> immediately all acu_rs_o are zero and stall=0, with no issue on the following edges.
- Ready dispatch: load, rd_tag=3, op=add, src1={0,1,5}, src2={0,1,7} -> one cycle later acu_rs_o[0]={3,1,12}, which clears the cycle after.
- Wakeup: dispatch sub, rd_tag=2, src1={5,0,x}, src2={0,1,4}; two cycles later bus[5]={5,1,10} -> on the edge after capture, acu_rs_o[0]={2,1,6}.
- Dispatch bypass: load with src1={6,0,x} while bus[6]={6,1,0xFFFFFFFF} in the same cycle, op=sra, src2={0,1,4} -> result 0xFFFFFFFF, tag correct, no hang.
- Full/stall: dispatch 8 entries all waiting on tag 7 -> stall=1 after the 8th. Assert bus[7]={7,1,1} -> the entries issue one per cycle over 8 cycles, in slots 0..7 in order. stall drops after the first issue edge.
- ALU sweep: slt with -1 vs 1 -> 1; sltu with 0xFFFFFFFF vs 1 -> 0; sll by 33 (using [4:0]=1) of 1 -> 2. Same-cycle dispatch and issue into different slots -> both occur correctly.
